// File: rtl/icache_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icache_controller_pkg
// Description : Shared instruction-cache typedefs (controller state encoding).
// Revision    : 1.0 - initial release
// ============================================================================
package icache_controller_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MISS  = 2'd1,
        WRITE = 2'd2,
        FLUSH = 2'd3
    } type_icache_states_e;

endpackage
`default_nettype wire

// File: rtl/icache_controller.sv
`default_nettype none
// ============================================================================
// Module      : icache_controller
// Description : Instruction-cache control FSM: hit ack, line refill, flush,
//               with saturating hit/miss performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_controller
    import icache_controller_pkg::*;
#(
    parameter int PERF_CNT_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  if2icache_req_i,
    input  logic                  if2icache_kill_i,
    output logic                  icache2if_ack_o,
    input  logic                  cache_hit_i,
    output logic                  cache_rw_o,
    output logic                  icache_flush_o,
    output logic                  icache2imem_req_o,
    input  logic                  imem2icache_ack_i,
    input  logic                  flush_req_i,
    output logic                  flush_ack_o,
    output logic [PERF_CNT_W-1:0] hit_cnt_o,
    output logic [PERF_CNT_W-1:0] miss_cnt_o
);

    localparam logic [PERF_CNT_W-1:0] c_CNT_ONE = {{(PERF_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PERF_CNT_W-1:0] c_CNT_MAX = {PERF_CNT_W{1'b1}};

    type_icache_states_e r_state;
    type_icache_states_e w_next_state;

    logic                  r_kill_seen;
    logic                  r_flush_pend;
    logic                  r_ack;
    logic                  r_refill;
    logic [PERF_CNT_W-1:0] r_hit_cnt;
    logic [PERF_CNT_W-1:0] r_miss_cnt;

    logic w_flush_go;
    logic w_fetch;
    logic w_hit_accept;
    logic w_miss_accept;

    // r_ack blocks re-acceptance while the IF stage still holds the acked request
    assign w_flush_go    = (r_state == IDLE) && (r_flush_pend || flush_req_i);
    assign w_fetch       = (r_state == IDLE) && if2icache_req_i && !if2icache_kill_i
                           && !w_flush_go && !r_ack;
    assign w_hit_accept  = w_fetch && cache_hit_i;
    assign w_miss_accept = w_fetch && !cache_hit_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_flush_go) begin
                    w_next_state = FLUSH;
                end else if (w_miss_accept) begin
                    w_next_state = MISS;
                end
            end
            MISS: begin
                if (imem2icache_ack_i) begin
                    w_next_state = (r_kill_seen || if2icache_kill_i) ? IDLE : WRITE;
                end
            end
            WRITE:   w_next_state = IDLE;
            FLUSH:   w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        cache_rw_o        = 1'b0;
        icache_flush_o    = 1'b0;
        flush_ack_o       = 1'b0;
        icache2imem_req_o = 1'b0;
        case (r_state)
            MISS:  icache2imem_req_o = 1'b1;
            WRITE: cache_rw_o        = 1'b1;
            FLUSH: begin
                icache_flush_o = 1'b1;
                flush_ack_o    = 1'b1;
            end
            default: ;
        endcase
    end

    // r_refill marks the re-lookup cycle right after a line write
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ack        <= 1'b0;
            r_refill     <= 1'b0;
            r_flush_pend <= 1'b0;
            r_kill_seen  <= 1'b0;
            r_hit_cnt    <= '0;
            r_miss_cnt   <= '0;
        end else begin
            r_ack        <= w_hit_accept;
            r_refill     <= (r_state == WRITE);
            r_flush_pend <= (r_state == FLUSH) ? 1'b0 : (r_flush_pend || flush_req_i);
            if (r_state == MISS) begin
                r_kill_seen <= imem2icache_ack_i ? 1'b0 : (r_kill_seen || if2icache_kill_i);
            end else begin
                r_kill_seen <= 1'b0;
            end
            if (w_hit_accept && !r_refill && (r_hit_cnt != c_CNT_MAX)) begin
                r_hit_cnt <= r_hit_cnt + c_CNT_ONE;
            end
            if (w_miss_accept && (r_miss_cnt != c_CNT_MAX)) begin
                r_miss_cnt <= r_miss_cnt + c_CNT_ONE;
            end
        end
    end

    assign icache2if_ack_o = r_ack;
    assign hit_cnt_o       = r_hit_cnt;
    assign miss_cnt_o      = r_miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_icache_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_controller
// Description : Directed self-checking bench for icache_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_controller;

    localparam int c_W = 16;

    logic           clk;
    logic           rst;
    logic           req;
    logic           kill;
    logic           ack;
    logic           hit;
    logic           rw;
    logic           flsh;
    logic           mreq;
    logic           mack;
    logic           freq;
    logic           fack;
    logic [c_W-1:0] hcnt;
    logic [c_W-1:0] mcnt;

    int n_cmp = 0;
    int n_err = 0;

    icache_controller #(.PERF_CNT_W(c_W)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .if2icache_req_i   (req),
        .if2icache_kill_i  (kill),
        .icache2if_ack_o   (ack),
        .cache_hit_i       (hit),
        .cache_rw_o        (rw),
        .icache_flush_o    (flsh),
        .icache2imem_req_o (mreq),
        .imem2icache_ack_i (mack),
        .flush_req_i       (freq),
        .flush_ack_o       (fack),
        .hit_cnt_o         (hcnt),
        .miss_cnt_o        (mcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output vector order: {ack, rw, flush, mem_req, flush_ack}
    task automatic chk_out(input string tag, input logic [4:0] exp);
        chk(tag, {27'd0, ack, rw, flsh, mreq, fack}, {27'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("excl", 32'((int'(rw) + int'(flsh) + int'(mreq)) > 1), 32'd0);
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; kill = 1'b0; hit = 1'b0; mack = 1'b0; freq = 1'b0;
        tick(); tick();
        chk_out("rst_out", 5'b00000);
        chk("rst_hc", 32'(hcnt), 32'd0);
        chk("rst_mc", 32'(mcnt), 32'd0);
        rst = 1'b0;

        // Cold miss, memory answers in the fifth miss cycle
        req = 1'b1; hit = 1'b0;
        tick(); chk_out("t1_miss", 5'b00010);
        chk("t1_mc", 32'(mcnt), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick(); chk_out("t1_wait", 5'b00010);
        end
        mack = 1'b1;
        tick(); chk_out("t1_write", 5'b01000);
        mack = 1'b0; hit = 1'b1;
        tick(); chk_out("t1_relook", 5'b00000);
        tick(); chk_out("t1_ack", 5'b10000);
        chk("t1_mc2", 32'(mcnt), 32'd1);
        chk("t1_hc", 32'(hcnt), 32'd0);
        req = 1'b0; hit = 1'b0;
        tick(); chk_out("t1_idle", 5'b00000);

        // Repeat fetch hits
        req = 1'b1; hit = 1'b1;
        tick(); chk_out("t2_ack", 5'b10000);
        chk("t2_hc", 32'(hcnt), 32'd1);
        req = 1'b0; hit = 1'b0;
        tick(); chk_out("t2_single", 5'b00000);

        // Kill two cycles into a miss
        req = 1'b1; hit = 1'b0;
        tick(); chk_out("t3_miss", 5'b00010);
        chk("t3_mc", 32'(mcnt), 32'd2);
        tick(); chk_out("t3_miss2", 5'b00010);
        kill = 1'b1; req = 1'b0;
        tick(); chk_out("t3_hold", 5'b00010);
        kill = 1'b0;
        tick(); chk_out("t3_hold2", 5'b00010);
        mack = 1'b1;
        tick(); chk_out("t3_nowrite", 5'b00000);
        mack = 1'b0;
        tick(); chk_out("t3_noack", 5'b00000);
        chk("t3_mc2", 32'(mcnt), 32'd2);

        // Flush request during a miss is deferred until after the refill
        req = 1'b1; hit = 1'b0;
        tick(); chk_out("t4_miss", 5'b00010);
        chk("t4_mc", 32'(mcnt), 32'd3);
        freq = 1'b1;
        tick(); chk_out("t4_pend", 5'b00010);
        freq = 1'b0; mack = 1'b1;
        tick(); chk_out("t4_write", 5'b01000);
        mack = 1'b0; hit = 1'b1;
        tick(); chk_out("t4_idle", 5'b00000);
        tick(); chk_out("t4_flush", 5'b00101);
        hit = 1'b0;
        tick(); chk_out("t4_post", 5'b00000);
        tick(); chk_out("t4_remiss", 5'b00010);
        chk("t4_mc2", 32'(mcnt), 32'd4);
        mack = 1'b1;
        tick(); chk_out("t4_write2", 5'b01000);
        mack = 1'b0; hit = 1'b1;
        tick(); chk_out("t4_relook", 5'b00000);
        tick(); chk_out("t4_ack", 5'b10000);
        chk("t4_hc", 32'(hcnt), 32'd1);
        req = 1'b0; hit = 1'b0;
        tick(); chk_out("t4_end", 5'b00000);

        // Flush and hit in the same IDLE cycle: flush wins
        req = 1'b1; hit = 1'b1; freq = 1'b1;
        tick(); chk_out("t5_flush", 5'b00101);
        freq = 1'b0; hit = 1'b0;
        tick(); chk_out("t5_noack", 5'b00000);
        tick(); chk_out("t5_miss", 5'b00010);
        chk("t5_mc", 32'(mcnt), 32'd5);
        mack = 1'b1;
        tick(); chk_out("t5_write", 5'b01000);
        mack = 1'b0; req = 1'b0;
        tick(); chk_out("t5_end", 5'b00000);
        chk("t5_hc", 32'(hcnt), 32'd1);

        // Miss counter saturation, then reset in the middle of a miss
        force dut.r_miss_cnt = 16'hFFFF;
        tick();
        release dut.r_miss_cnt;
        chk("t6_pre", 32'(mcnt), 32'h0000FFFF);
        req = 1'b1; hit = 1'b0;
        tick(); chk_out("t6_miss", 5'b00010);
        chk("t6_sat", 32'(mcnt), 32'h0000FFFF);
        tick(); chk_out("t6_miss2", 5'b00010);
        rst = 1'b1;
        tick(); chk_out("t6_rst", 5'b00000);
        chk("t6_rst_mc", 32'(mcnt), 32'd0);
        chk("t6_rst_hc", 32'(hcnt), 32'd0);
        rst = 1'b0; req = 1'b0;
        tick(); chk_out("t6_idle", 5'b00000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
